// File: rtl/b16_mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : b16_mem_arb_if
//  Purpose  : Bundle of CPU, host and memory signals around the b16 memory
//             arbiter.
//             slave  : arbiter view (drives cpu_din/cpu_run, host_ack/rdata
//                      and the mem_* strobes/address/data).
//             master : environment view (CPU, host, memory and run_en).
//  Ports    : run_en, cpu_addr/rd/wr/dout -> cpu_din/run,
//             host_req/addr/rd/wr/wdata -> host_ack/rdata,
//             mem_addr/rd/wr/wdata <- mem_rdata.
//  Revision : 1.0  initial release
// ============================================================================
interface b16_mem_arb_if #(
  parameter int l = 16
);
  logic         run_en;
  logic [l-1:0] cpu_addr;
  logic         cpu_rd;
  logic [1:0]   cpu_wr;
  logic [l-1:0] cpu_dout;
  logic [l-1:0] cpu_din;
  logic         cpu_run;
  logic         host_req;
  logic [l-1:0] host_addr;
  logic         host_rd;
  logic [1:0]   host_wr;
  logic [l-1:0] host_wdata;
  logic         host_ack;
  logic [l-1:0] host_rdata;
  logic [l-1:0] mem_addr;
  logic         mem_rd;
  logic [1:0]   mem_wr;
  logic [l-1:0] mem_wdata;
  logic [l-1:0] mem_rdata;

  modport slave (
    input  run_en, cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    input  host_req, host_addr, host_rd, host_wr, host_wdata,
    input  mem_rdata,
    output cpu_din, cpu_run, host_ack, host_rdata,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output run_en, cpu_addr, cpu_rd, cpu_wr, cpu_dout,
    output host_req, host_addr, host_rd, host_wr, host_wdata,
    output mem_rdata,
    input  cpu_din, cpu_run, host_ack, host_rdata,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/b16_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : b16_mem_arb
//  Purpose  : Shares one memory port between the b16 CPU and a debug host.
//             The CPU owns the port by default; a host request is granted
//             only at a CPU access boundary and the host may then perform up
//             to HOLD back-to-back accesses (unlimited while run_en=0).
//             Every access lasts WAIT+1 clocks.
//  Ports    : clk    - sole clock, rising edge
//             nreset - asynchronous active-low reset
//             bus    - b16_mem_arb_if.slave (CPU, host and memory signals)
//  Params   : l    - data/address width
//             WAIT - extra wait cycles per access (0..7)
//             HOLD - max consecutive host accesses (1..15)
//  Revision : 1.0  initial release
// ============================================================================
module b16_mem_arb #(
  parameter int l    = 16,
  parameter int WAIT = 0,
  parameter int HOLD = 4
) (
  input  wire logic      clk,
  input  wire logic      nreset,
  b16_mem_arb_if.slave   bus
);

  localparam logic [2:0] c_WAIT = 3'(WAIT);
  localparam logic [3:0] c_HOLD = 4'(HOLD);

  typedef enum logic [0:0] {
    ST_CPU  = 1'b0,
    ST_HOST = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_wcnt;
  logic [2:0]   w_wcnt_nxt;
  logic [3:0]   r_hcnt;
  logic [3:0]   w_hcnt_nxt;

  logic         w_cpu_pend;
  logic         w_wait_done;
  logic         w_cpu_run;
  logic         w_host_ack;
  logic [4:0]   w_hcnt_inc;
  logic [l-1:0] w_mem_addr;
  logic [l-1:0] w_mem_wdata;
  logic         w_mem_rd;
  logic [1:0]   w_mem_wr;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_CPU;
      r_wcnt  <= 3'd0;
      r_hcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_hcnt_nxt  = r_hcnt;

    w_wait_done = (r_wcnt == c_WAIT);
    w_cpu_pend  = (r_state == ST_CPU) && bus.run_en &&
                  (bus.cpu_rd || (|bus.cpu_wr));
    w_cpu_run   = (r_state == ST_CPU) && bus.run_en &&
                  (!w_cpu_pend || w_wait_done);
    w_host_ack  = (r_state == ST_HOST) && bus.host_req && w_wait_done;
    // One bit wider so the HOLD comparison cannot wrap.
    w_hcnt_inc  = {1'b0, r_hcnt} + 5'd1;

    // Memory port mux follows the current owner.
    if (r_state == ST_HOST) begin
      w_mem_addr  = bus.host_addr;
      w_mem_wdata = bus.host_wdata;
      w_mem_rd    = bus.host_rd & bus.host_req;
      w_mem_wr    = bus.host_wr & {2{bus.host_req}};
    end else begin
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_dout;
      w_mem_rd    = bus.cpu_rd & bus.run_en;
      w_mem_wr    = bus.cpu_wr & {2{bus.run_en}};
    end

    case (r_state)
      ST_CPU: begin
        if (w_cpu_pend) begin
          w_wcnt_nxt = w_wait_done ? 3'd0 : (r_wcnt + 3'd1);
        end
        // Hand over only when the CPU is at a boundary (its access just
        // completed, or it is halted), never mid-wait.
        if ((w_cpu_run || !bus.run_en) && bus.host_req) begin
          w_state_nxt = ST_HOST;
          w_wcnt_nxt  = 3'd0;
          w_hcnt_nxt  = 4'd0;
        end
      end

      ST_HOST: begin
        if (!bus.host_req) begin
          // Request withdrawn before completion: abandon the access.
          w_state_nxt = ST_CPU;
          w_wcnt_nxt  = 3'd0;
        end else if (w_wait_done) begin
          w_wcnt_nxt = 3'd0;
          w_hcnt_nxt = (w_hcnt_inc >= {1'b0, c_HOLD}) ? c_HOLD : w_hcnt_inc[3:0];
          // A halted CPU cannot use the port, so the host keeps it.
          if (!((w_hcnt_inc < {1'b0, c_HOLD}) || !bus.run_en)) begin
            w_state_nxt = ST_CPU;
          end
        end else begin
          w_wcnt_nxt = r_wcnt + 3'd1;
        end
      end

      default: begin
        w_state_nxt = ST_CPU;
        w_wcnt_nxt  = 3'd0;
        w_hcnt_nxt  = 4'd0;
      end
    endcase
  end

  assign bus.cpu_run    = w_cpu_run;
  assign bus.host_ack   = w_host_ack;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_rd     = w_mem_rd;
  assign bus.mem_wr     = w_mem_wr;
  assign bus.cpu_din    = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;

endmodule
`default_nettype wire
